// File: rtl/vq_codebook_accum.sv
// vq_codebook_accum: per-codeword accumulator for LBG centroid update.
// Each accepted frame adds the buffered DIM-element MFCC vector into the sum
// bin of the winning codeword and bumps that codeword's frame count. Sums
// and counts are read back through a host port once the session is done.
// Optional build macro VQ_ACC_SAT_EN: saturating accumulate (sets err on
// saturation) instead of the default two's-complement wrap.
module vq_codebook_accum #(
    parameter int NUM_CW = 16,
    parameter int DIM    = 13,
    parameter int DATA_W = 14,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 9,
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 10,
    parameter int DIM_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              vec_wr_en,
    input  logic [DIM_W-1:0]  vec_wr_addr,
    input  logic [DATA_W-1:0] vec_wr_data,
    input  logic              min_valid,
    input  logic [IDX_W-1:0]  min_idx,
    output logic              min_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ACC_W-1:0]  rd_data,
    input  logic [IDX_W-1:0]  cnt_rd_idx,
    output logic [CNT_W-1:0]  cnt_rd_data
);

    // Storage geometry and the exact index widths of each array.
    localparam int NUM_WORDS = NUM_CW * DIM;
    localparam int WA = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CA = (NUM_CW > 1) ? $clog2(NUM_CW) : 1;
    localparam int VA = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic [WA-1:0]    CLR_LAST  = WA'(NUM_WORDS - 1);
    localparam logic [DIM_W:0]   ACC_LAST  = (DIM_W + 1)'(DIM + 1);
    localparam logic [DIM_W:0]   DIM_LIM   = (DIM_W + 1)'(DIM);
    localparam logic [IDX_W:0]   CW_LIM    = (IDX_W + 1)'(NUM_CW);
    localparam logic [ADDR_W:0]  WORDS_LIM = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READY = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Accumulate one coefficient into a running sum; the MSB of the return
    // value flags a saturation event (always 0 in the wrapping build).
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [DATA_W-1:0] coef);
`ifdef VQ_ACC_SAT_EN
        logic signed [ACC_W:0] wide;
        logic                  ovf;
        wide = (ACC_W + 1)'($signed(acc)) + (ACC_W + 1)'($signed(coef));
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        if (ovf) begin
            if (wide[ACC_W]) begin
                return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            return {1'b0, wide[ACC_W-1:0]};
        end
`else
        logic [ACC_W-1:0] ext;
        ext = ACC_W'($signed(coef));
        return {1'b0, acc + ext};
`endif
    endfunction

    state_t            state_r;
    state_t            next_s;
    logic [WA-1:0]     clr_addr_r;
    logic [DIM_W:0]    k_r;
    logic [WA-1:0]     ptr_r;
    logic              fin_pend_r;

    logic [DATA_W-1:0] vec_r     [0:DIM-1];
    logic [CNT_W-1:0]  cnt_r     [0:NUM_CW-1];
    logic [ACC_W-1:0]  sum_mem_r [0:NUM_WORDS-1];

    logic              s1_vld_r;
    logic [WA-1:0]     s1_addr_r;
    logic [ACC_W-1:0]  s1_ram_r;
    logic [DATA_W-1:0] s1_vec_r;
    logic              s2_vld_r;
    logic [WA-1:0]     s2_addr_r;
    logic [ACC_W-1:0]  s2_sum_r;

    logic              idx_ok_s;
    logic              accept_s;
    logic              bad_idx_s;
    logic              vec_wr_bad_s;
    logic              vec_wr_ok_s;
    logic              load_s;
    logic              add_sat_s;
    logic [ACC_W-1:0]  add_sum_s;
    logic              sat_evt_s;

    // Decode the qualifying events for this cycle; start overrides everything.
    always_comb begin
        idx_ok_s     = ({1'b0, min_idx} < CW_LIM);
        accept_s     = (state_r == ST_READY) && min_valid && idx_ok_s && !start;
        bad_idx_s    = (state_r == ST_READY) && min_valid && !idx_ok_s && !start;
        vec_wr_bad_s = (state_r == ST_ACCUM) && vec_wr_en && !start;
        vec_wr_ok_s  = (state_r != ST_ACCUM) && vec_wr_en &&
                       ({1'b0, vec_wr_addr} < DIM_LIM);
        load_s       = (state_r == ST_ACCUM) && (k_r < DIM_LIM);
        {add_sat_s, add_sum_s} = acc_add(s1_ram_r, s1_vec_r);
        sat_evt_s    = s1_vld_r && add_sat_s;
    end

    // Next-state selection for the session controller.
    always_comb begin
        next_s = state_r;
        if (start) begin
            next_s = ST_CLEAR;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_s = ST_IDLE;
                end
                ST_CLEAR: begin
                    if (clr_addr_r == CLR_LAST) begin
                        next_s = ST_READY;
                    end else begin
                        next_s = ST_CLEAR;
                    end
                end
                ST_READY: begin
                    if (min_valid && idx_ok_s) begin
                        next_s = ST_ACCUM;
                    end else if (finish) begin
                        next_s = ST_DONE;
                    end else begin
                        next_s = ST_READY;
                    end
                end
                ST_ACCUM: begin
                    if (k_r == ACC_LAST) begin
                        if (fin_pend_r || finish) begin
                            next_s = ST_DONE;
                        end else begin
                            next_s = ST_READY;
                        end
                    end else begin
                        next_s = ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    next_s = ST_DONE;
                end
                default: begin
                    next_s = ST_CLEAR;
                end
            endcase
        end
    end

    // Session FSM: state, clear/accumulate counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= {WA{1'b0}};
            k_r        <= {(DIM_W+1){1'b0}};
            ptr_r      <= {WA{1'b0}};
            fin_pend_r <= 1'b0;
            min_ready  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_r   <= next_s;
            min_ready <= (next_s == ST_READY);
            busy      <= (next_s == ST_CLEAR) || (next_s == ST_ACCUM);
            done      <= (next_s == ST_DONE);

            // The clear sweep always restarts from address 0 on start.
            if (start) begin
                clr_addr_r <= {WA{1'b0}};
            end else if (state_r == ST_CLEAR) begin
                clr_addr_r <= clr_addr_r + WA'(1);
            end else begin
                clr_addr_r <= clr_addr_r;
            end

            // Element counter and RAM pointer for the accumulate pass.
            if (accept_s) begin
                k_r   <= {(DIM_W+1){1'b0}};
                ptr_r <= WA'(min_idx) * WA'(DIM);
            end else if (state_r == ST_ACCUM) begin
                k_r   <= k_r + (DIM_W+1)'(1);
                ptr_r <= ptr_r + WA'(1);
            end else begin
                k_r   <= k_r;
                ptr_r <= ptr_r;
            end

            // A finish seen while a frame is in flight is honoured at its end.
            if (start) begin
                fin_pend_r <= 1'b0;
            end else if (accept_s) begin
                fin_pend_r <= finish;
            end else if (state_r == ST_ACCUM) begin
                if (k_r == ACC_LAST) begin
                    fin_pend_r <= 1'b0;
                end else begin
                    fin_pend_r <= fin_pend_r | finish;
                end
            end else begin
                fin_pend_r <= fin_pend_r;
            end

            // Sticky error, cleared only by a new session.
            if (start) begin
                err <= 1'b0;
            end else if (bad_idx_s || vec_wr_bad_s || sat_evt_s) begin
                err <= 1'b1;
            end else begin
                err <= err;
            end
        end
    end

    // Frame vector buffer; frozen while a frame is being accumulated.
    always_ff @(posedge clk) begin
        if (vec_wr_ok_s) begin
            vec_r[vec_wr_addr[VA-1:0]] <= vec_wr_data;
        end else begin
            vec_r[vec_wr_addr[VA-1:0]] <= vec_r[vec_wr_addr[VA-1:0]];
        end
    end

    // Frame counts: bulk clear on the first clear cycle, saturating increment on accept.
    always_ff @(posedge clk) begin
        if ((state_r == ST_CLEAR) && (clr_addr_r == {WA{1'b0}})) begin
            for (int i = 0; i < NUM_CW; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else if (accept_s) begin
            if (cnt_r[min_idx[CA-1:0]] != CNT_MAX) begin
                cnt_r[min_idx[CA-1:0]] <= cnt_r[min_idx[CA-1:0]] + CNT_W'(1);
            end else begin
                cnt_r[min_idx[CA-1:0]] <= CNT_MAX;
            end
        end else begin
            cnt_r[min_idx[CA-1:0]] <= cnt_r[min_idx[CA-1:0]];
        end
    end

    // Read-modify-write pipeline: stage 1 fetches RAM + coefficient, stage 2 holds the sum.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            s1_vld_r <= 1'b0;
            s2_vld_r <= 1'b0;
        end else begin
            s1_vld_r <= load_s;
            s2_vld_r <= s1_vld_r;
        end
        if (load_s) begin
            s1_addr_r <= ptr_r;
            s1_ram_r  <= sum_mem_r[ptr_r];
            s1_vec_r  <= vec_r[k_r[VA-1:0]];
        end else begin
            s1_addr_r <= s1_addr_r;
            s1_ram_r  <= s1_ram_r;
            s1_vec_r  <= s1_vec_r;
        end
        s2_addr_r <= s1_addr_r;
        s2_sum_r  <= add_sum_s;
    end

    // Sum RAM write port: sequential clear sweep or pipeline write-back.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            sum_mem_r[clr_addr_r] <= {ACC_W{1'b0}};
        end else if (s2_vld_r) begin
            sum_mem_r[s2_addr_r] <= s2_sum_r;
        end else begin
            sum_mem_r[s2_addr_r] <= sum_mem_r[s2_addr_r];
        end
    end

    // Host read port: refreshed only while idle-side, holds while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data     <= {ACC_W{1'b0}};
            cnt_rd_data <= {CNT_W{1'b0}};
        end else if (!busy) begin
            if ({1'b0, rd_addr} < WORDS_LIM) begin
                rd_data <= sum_mem_r[rd_addr[WA-1:0]];
            end else begin
                rd_data <= {ACC_W{1'b0}};
            end
            if ({1'b0, cnt_rd_idx} < CW_LIM) begin
                cnt_rd_data <= cnt_r[cnt_rd_idx[CA-1:0]];
            end else begin
                cnt_rd_data <= {CNT_W{1'b0}};
            end
        end else begin
            rd_data     <= rd_data;
            cnt_rd_data <= cnt_rd_data;
        end
    end

endmodule

// File: tb/tb_vq_codebook_accum.sv
// Directed bench for vq_codebook_accum with 16-bit coefficients and sums
// so that accumulator overflow can be provoked with in-range inputs.
module tb_vq_codebook_accum;

    localparam int NUM_CW = 16;
    localparam int DIM    = 13;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 9;
    localparam int IDX_W  = 6;
    localparam int ADDR_W = 10;
    localparam int DIM_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              finish;
    logic              vec_wr_en;
    logic [DIM_W-1:0]  vec_wr_addr;
    logic [DATA_W-1:0] vec_wr_data;
    logic              min_valid;
    logic [IDX_W-1:0]  min_idx;
    logic              min_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] rd_addr;
    logic [ACC_W-1:0]  rd_data;
    logic [IDX_W-1:0]  cnt_rd_idx;
    logic [CNT_W-1:0]  cnt_rd_data;

    int checks = 0;
    int errors = 0;

    vq_codebook_accum #(
        .NUM_CW(NUM_CW), .DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W),
        .CNT_W(CNT_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
        .min_valid(min_valid), .min_idx(min_idx), .min_ready(min_ready),
        .busy(busy), .done(done), .err(err),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .cnt_rd_idx(cnt_rd_idx), .cnt_rd_data(cnt_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rd_sum(input int addr, input int exp, input string tag);
        rd_addr = ADDR_W'(addr);
        tick();
        chk(tag, $signed(rd_data), exp);
    endtask

    task automatic rd_cnt(input int idx, input int exp, input string tag);
        cnt_rd_idx = IDX_W'(idx);
        tick();
        chk(tag, cnt_rd_data, exp);
    endtask

    task automatic scan_zero(input string tag);
        int bad = 0;
        for (int i = 0; i < NUM_CW * DIM; i++) begin
            rd_addr = ADDR_W'(i);
            tick();
            if (rd_data !== '0) bad++;
        end
        for (int i = 0; i < NUM_CW; i++) begin
            cnt_rd_idx = IDX_W'(i);
            tick();
            if (cnt_rd_data !== '0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (min_ready !== 1'b1 && n < 600) begin
            tick();
            n++;
        end
        chk(tag, min_ready, 1);
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < DIM; i++) begin
            vec_wr_en   = 1'b1;
            vec_wr_addr = DIM_W'(i);
            vec_wr_data = DATA_W'(v);
            tick();
        end
        vec_wr_en = 1'b0;
    endtask

    task automatic frame(input int idx);
        wait_ready("frame_ready");
        min_valid = 1'b1;
        min_idx   = IDX_W'(idx);
        tick();
        min_valid = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; finish = 1'b0;
        vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_data = '0;
        min_valid = 1'b0; min_idx = '0; rd_addr = '0; cnt_rd_idx = '0;

        // Reset state
        tick();
        tick();
        chk("rst_min_ready", min_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cnt_rd_data", cnt_rd_data, 0);
        rst = 1'b0;

        // Clear sweep lasts NUM_CW*DIM cycles
        n = 0;
        while (min_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("clear_cycles", n, 208);
        chk("ready_not_busy", busy, 0);
        scan_zero("clear_after_rst");

        // Ramp vector into codeword 3, finish during ACCUM
        for (int i = 0; i < DIM; i++) begin
            vec_wr_en = 1'b1; vec_wr_addr = DIM_W'(i); vec_wr_data = DATA_W'(i + 1);
            tick();
        end
        vec_wr_en = 1'b0;
        min_valid = 1'b1; min_idx = 6'd3;
        tick();
        min_valid = 1'b0; finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("accum_busy", busy, 1);
        repeat (13) tick();
        chk("done_not_early", done, 0);
        tick();
        chk("done_on_time", done, 1);
        chk("done_min_ready", min_ready, 0);
        rd_sum(38, 0, "ramp_below_bin");
        for (int i = 0; i < DIM; i++) begin
            rd_sum(39 + i, i + 1, "ramp_sum");
        end
        rd_sum(1000, 0, "out_of_range_read");
        rd_sum(52, 0, "ramp_above_bin");
        rd_cnt(3, 1, "ramp_count");
        rd_cnt(2, 0, "ramp_other_count");
        min_valid = 1'b1; min_idx = 6'd3;
        tick();
        min_valid = 1'b0;
        chk("done_ignores_valid", done, 1);
        rd_cnt(3, 1, "done_count_unchanged");

        // Back-to-back frames of -5 into codeword 0
        do_start();
        chk("start_busy", busy, 1);
        wait_ready("after_start");
        chk("start_err", err, 0);
        load_vec(-5);
        frame(0);
        frame(0);
        frame(0);
        wait_ready("b2b_ready");
        finish = 1'b1;
        tick();
        finish = 1'b0;
        chk("finish_in_ready_done", done, 1);
        for (int i = 0; i < DIM; i++) begin
            rd_sum(i, -15, "b2b_sum");
        end
        rd_sum(13, 0, "b2b_next_bin");
        rd_cnt(0, 3, "b2b_count");
        rd_cnt(1, 0, "b2b_other_count");

        // Out-of-range index is dropped
        do_start();
        wait_ready("bad_idx_ready");
        min_valid = 1'b1; min_idx = 6'd16;
        tick();
        min_valid = 1'b0;
        chk("bad_idx_err", err, 1);
        chk("bad_idx_min_ready", min_ready, 1);
        tick();
        chk("bad_idx_still_ready", min_ready, 1);
        scan_zero("bad_idx_no_change");

        // Vector write during ACCUM is ignored and flagged
        do_start();
        wait_ready("vwr_ready");
        chk("start_clears_err", err, 0);
        load_vec(2);
        frame(7);
        vec_wr_en = 1'b1; vec_wr_addr = 4'd12; vec_wr_data = 16'd100;
        tick();
        vec_wr_en = 1'b0;
        chk("vwr_accum_err", err, 1);
        wait_ready("vwr_done");
        rd_sum(91, 2, "vwr_first_elem");
        rd_sum(103, 2, "vwr_last_elem_old");
        frame(8);
        wait_ready("vwr_next_done");
        rd_sum(116, 2, "vwr_buffer_unchanged");

        // start during ACCUM wipes prior data and err
        do_start();
        wait_ready("mid_ready");
        min_valid = 1'b1; min_idx = 6'd20;
        tick();
        min_valid = 1'b0;
        chk("mid_pre_err", err, 1);
        load_vec(4);
        frame(5);
        wait_ready("mid_frame1");
        rd_sum(65, 4, "mid_prior_data");
        frame(5);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_busy", busy, 1);
        chk("mid_err_cleared", err, 0);
        wait_ready("mid_after_clear");
        scan_zero("mid_accum_cleared");
        chk("mid_err_after", err, 0);

        // Overflow: three frames of +16000 into codeword 0
        load_vec(16000);
        frame(0);
        frame(0);
        frame(0);
        wait_ready("ovf_ready");
`ifdef VQ_ACC_SAT_EN
        rd_sum(0, 32767, "ovf_sat_first");
        rd_sum(12, 32767, "ovf_sat_last");
        chk("ovf_sat_err", err, 1);
`else
        rd_sum(0, -17536, "ovf_wrap_first");
        rd_sum(12, -17536, "ovf_wrap_last");
        chk("ovf_wrap_err", err, 0);
`endif

        // Count saturation after 600 frames
        load_vec(0);
        for (int f = 0; f < 600; f++) begin
            frame(1);
        end
        wait_ready("cnt_sat_ready");
        rd_cnt(1, 511, "cnt_saturated");
        rd_cnt(0, 3, "cnt_other_bin");
        rd_sum(13, 0, "cnt_sat_sum_zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
